// File: rtl/clk_sw_pkg.sv
// Shared types and default parameters for the clka/clkb clock-switch controller.
package clk_sw_pkg;

  typedef enum logic [1:0] {
    ON_A = 2'd0,
    SW_B = 2'd1,
    ON_B = 2'd2,
    SW_A = 2'd3
  } clk_sw_state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_WIN_W       = 8;
  localparam int unsigned DEF_MIN_EDGES   = 4;
  localparam int unsigned DEF_SETTLE_CYC  = 16;

endpackage

// File: rtl/clk_sw_mon.sv
// clkb activity monitor: a clkb toggle flop resynchronised into clka and counted per window.
// The toggle flop is the only logic clocked by clkb.
module clk_sw_mon
  import clk_sw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned WIN_W       = DEF_WIN_W,
  parameter int unsigned MIN_EDGES   = DEF_MIN_EDGES
) (
  input  logic rst_n,
  input  logic clka,
  input  logic clkb,
  output logic clkb_ok
);

  localparam int unsigned EC_W = $clog2(MIN_EDGES + 1);
  localparam logic [EC_W-1:0] EC_MAX = EC_W'(MIN_EDGES);

  logic                   tgl_b_q, tgl_b_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [EC_W-1:0]        edge_cnt_q, edge_cnt_d;
  logic                   clkb_ok_q, clkb_ok_d;
  logic                   chg;
  logic                   win_last;

  assign tgl_b_d = ~tgl_b_q;

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) tgl_b_q <= 1'b0;
    else        tgl_b_q <= tgl_b_d;
  end

  // SYNC_STAGES must be at least 2; the toggle enters at bit 0.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], tgl_b_q};
  assign prev_d   = sync_q[SYNC_STAGES-1];
  assign chg      = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign win_d    = win_q + WIN_W'(1);
  assign win_last = &win_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    clkb_ok_d  = clkb_ok_q;
    if (win_last) begin
      clkb_ok_d  = (edge_cnt_q >= EC_MAX);
      edge_cnt_d = '0;
    end else if (chg && (edge_cnt_q < EC_MAX)) begin
      edge_cnt_d = edge_cnt_q + EC_W'(1);
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      win_q      <= '0;
      edge_cnt_q <= '0;
      clkb_ok_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      win_q      <= win_d;
      edge_cnt_q <= edge_cnt_d;
      clkb_ok_q  <= clkb_ok_d;
    end
  end

  assign clkb_ok = clkb_ok_q;

endmodule

// File: rtl/clk_sw_ctrl.sv
// Clock-switch controller: drives the glitch-free mux select and falls back to clka
// when the clkb monitor stops seeing activity.
module clk_sw_ctrl
  import clk_sw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned WIN_W       = DEF_WIN_W,
  parameter int unsigned MIN_EDGES   = DEF_MIN_EDGES,
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC
) (
  input  logic          rst_n,
  input  logic          clka,
  input  logic          clkb,
  input  logic          req_clkb,
  output logic          sel_clkb,
  output logic          busy,
  output logic          on_clkb,
  output logic          clkb_ok,
  output logic          fail,
  output clk_sw_state_t dbg_state
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  clk_sw_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             on_clkb_q, on_clkb_d;
  logic             fail_q, fail_d;
  logic             ok;

  clk_sw_mon #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIN_W       (WIN_W),
    .MIN_EDGES   (MIN_EDGES)
  ) u_mon (
    .rst_n   (rst_n),
    .clka    (clka),
    .clkb    (clkb),
    .clkb_ok (ok)
  );

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ON_A;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      on_clkb_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      on_clkb_q <= on_clkb_d;
      fail_q    <= fail_d;
    end
  end

  // req_clkb is a level; the controller follows it only while busy is low, except that
  // a started SW_B/SW_A settle always runs to completion unless clkb dies in SW_B.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    case (state_q)
      ON_A: begin
        if (req_clkb && ok && !fail_q) begin
          state_d = SW_B;
          cnt_d   = CNT_LOAD;
        end else if (!req_clkb) begin
          fail_d = 1'b0;
        end
      end
      SW_B: begin
        if (!ok) begin
          state_d = SW_A;
          fail_d  = 1'b1;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ON_B;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ON_B: begin
        if (!ok || !req_clkb) begin
          state_d = SW_A;
          cnt_d   = CNT_LOAD;
          if (!ok) fail_d = 1'b1;
        end
      end
      SW_A: begin
        if (cnt_q == '0) state_d = ON_A;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ON_A;
    endcase
  end

  // Outputs decode the next state so they register on the same edge as sel_clkb.
  always_comb begin
    sel_d     = (state_d == SW_B) || (state_d == ON_B);
    busy_d    = (state_d == SW_B) || (state_d == SW_A);
    on_clkb_d = (state_d == ON_B);
  end

  assign sel_clkb  = sel_q;
  assign busy      = busy_q;
  assign on_clkb   = on_clkb_q;
  assign fail      = fail_q;
  assign clkb_ok   = ok;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_sw_ctrl.sv
// Bench for clk_sw_ctrl: per-cycle scoreboard against a behavioural model, plus
// directed scenarios and a randomised request/clkb activity phase.
module tb_clk_sw_ctrl;
  import clk_sw_pkg::*;

  localparam int S      = 2;
  localparam int WIN    = 256;
  localparam int MIN_E  = 4;
  localparam int SETTLE = 16;

  logic          clka, clkb, rst_n, req_clkb;
  logic          sel_clkb, busy, on_clkb, clkb_ok, fail;
  clk_sw_state_t dbg_state;
  logic          clkb_en;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  // Behavioural reference state
  logic tgl_m;
  bit   hist[$];
  int   mw, ecount, busy_left;
  bit   m_ok, m_sel, m_fail;

  clk_sw_ctrl #(
    .SYNC_STAGES (S),
    .WIN_W       (8),
    .MIN_EDGES   (MIN_E),
    .SETTLE_CYC  (SETTLE)
  ) dut (
    .rst_n     (rst_n),
    .clka      (clka),
    .clkb      (clkb),
    .req_clkb  (req_clkb),
    .sel_clkb  (sel_clkb),
    .busy      (busy),
    .on_clkb   (on_clkb),
    .clkb_ok   (clkb_ok),
    .fail      (fail),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  initial begin
    clkb = 1'b0;
    #3;
    forever begin
      #20;
      if (clkb_en) clkb = ~clkb;
    end
  end

  // reference model
  always @(posedge clkb or negedge rst_n) begin
    if (!rst_n) tgl_m <= 1'b0;
    else        tgl_m <= ~tgl_m;
  end

  always @(posedge clka) begin
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
      mw = 0; ecount = 0; busy_left = 0;
      m_ok = 0; m_sel = 0; m_fail = 0;
      exp_q.push_back(5'b0);
    end else begin
      bit det;
      hist.push_front(tgl_m);
      void'(hist.pop_back());
      det = (hist[S] != hist[S+1]);
      if (busy_left > 0) begin
        if (m_sel && !m_ok) begin
          m_sel = 0; m_fail = 1; busy_left = SETTLE;
        end else begin
          busy_left--;
        end
      end else if (m_sel) begin
        if (!m_ok) begin
          m_sel = 0; m_fail = 1; busy_left = SETTLE;
        end else if (!req_clkb) begin
          m_sel = 0; busy_left = SETTLE;
        end
      end else begin
        if (req_clkb && m_ok && !m_fail) begin
          m_sel = 1; busy_left = SETTLE;
        end else if (!req_clkb) begin
          m_fail = 0;
        end
      end
      if (mw == WIN - 1) begin
        m_ok   = (ecount >= MIN_E);
        ecount = 0;
      end else begin
        ecount += int'(det);
      end
      mw = (mw + 1) % WIN;
      exp_q.push_back({m_sel, (busy_left > 0), (m_sel && busy_left == 0), m_fail, m_ok});
    end
  end

  // scoreboard monitor
  always @(negedge clka) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e, g;
      e = exp_q.pop_front();
      g = {sel_clkb, busy, on_clkb, fail, clkb_ok};
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL cycle_cmp t=%0t {sel,busy,on,fail,ok} got=%b exp=%b", $time, g, e);
    end
  end

  // driver tasks
  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic wait_ok(input logic lvl, input int max, input string name);
    for (int i = 0; i < max && clkb_ok !== lvl; i++) @(negedge clka);
    chk1(name, clkb_ok, lvl);
  endtask

  // called at a negedge; reset lands between edges
  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_sel", sel_clkb, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_fail", fail, 1'b0);
    chk1("rst_on", on_clkb, 1'b0);
    chk1("rst_ok", clkb_ok, 1'b0);
    cyc(hold);
    #2 rst_n = 1'b1;
    @(negedge clka);
  endtask

  initial begin
    bit saw_on;
    int i;
    rst_n = 1'b0; req_clkb = 1'b0; clkb_en = 1'b0;
    cyc(5);
    #2 rst_n = 1'b1;

    // reset, clkb idle
    cyc(10);
    req_clkb = 1'b1;
    cyc(1000);
    chk1("idle_sel", sel_clkb, 1'b0);
    chk1("idle_fail", fail, 1'b0);
    chk1("idle_ok", clkb_ok, 1'b0);
    req_clkb = 1'b0;

    // normal switch
    clkb_en = 1'b1;
    wait_ok(1'b1, 520, "ok_rise");
    req_clkb = 1'b1;
    cyc(1);
    chk1("sw_sel", sel_clkb, 1'b1);
    chk1("sw_busy", busy, 1'b1);
    cyc(15);
    chk1("sw_busy_last", busy, 1'b1);
    cyc(1);
    chk1("sw_on", on_clkb, 1'b1);
    chk1("sw_busy_done", busy, 1'b0);

    // loss while on clkb
    clkb_en = 1'b0;
    wait_ok(1'b0, 520, "ok_fall");
    cyc(1);
    chk1("loss_sel", sel_clkb, 1'b0);
    chk1("loss_fail", fail, 1'b1);
    chk1("loss_busy", busy, 1'b1);
    cyc(16);
    chk1("loss_busy_done", busy, 1'b0);
    cyc(20);
    chk1("loss_req_ignored", sel_clkb, 1'b0);
    req_clkb = 1'b0;
    cyc(1);
    req_clkb = 1'b1;
    cyc(1);
    chk1("fail_clear", fail, 1'b0);
    req_clkb = 1'b0;

    // request dropped during SW_B
    clkb_en = 1'b1;
    wait_ok(1'b1, 520, "ok_rise2");
    req_clkb = 1'b1;
    cyc(5);
    req_clkb = 1'b0;
    cyc(12);
    chk1("drop_on_pulse", on_clkb, 1'b1);
    cyc(1);
    chk1("drop_back_busy", busy, 1'b1);
    chk1("drop_back_sel", sel_clkb, 1'b0);
    cyc(16);
    chk1("drop_back_done", busy, 1'b0);

    // loss coinciding with settle end
    for (i = 0; i < 300 && mw != 0; i++) @(negedge clka);
    clkb_en = 1'b0;
    for (i = 0; i < 300 && mw != WIN - 16; i++) @(negedge clka);
    req_clkb = 1'b1;
    saw_on = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clka);
      if (on_clkb === 1'b1) saw_on = 1'b1;
    end
    chk1("coinc_fail", fail, 1'b1);
    chk1("coinc_sel", sel_clkb, 1'b0);
    chk1("coinc_no_on", saw_on, 1'b0);
    req_clkb = 1'b0;
    cyc(20);

    // reset mid-switch
    clkb_en = 1'b1;
    wait_ok(1'b1, 520, "ok_rise3");
    req_clkb = 1'b1;
    cyc(8);
    chk1("mid_busy", busy, 1'b1);
    do_reset(3);
    cyc(100);
    chk1("requal_sel", sel_clkb, 1'b0);
    wait_ok(1'b1, 520, "ok_requal");
    cyc(1);
    chk1("requal_switch", sel_clkb, 1'b1);
    req_clkb = 1'b0;
    cyc(40);

    // randomised phase
    for (int r = 0; r < 25; r++) begin
      req_clkb = 1'($urandom_range(0, 1));
      clkb_en  = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(1, 600));
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 4));
    end
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_sw_ctrl.md
# clk_sw_ctrl

Clock-switch controller that drives the `sel_clkb` request of the team's glitch-free clka/clkb clock mux. It runs on the always-on clock clka and watches clkb for activity. It accepts a level request to move to clkb, holds busy for a fixed settle period, and falls back to clka if clkb stops.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for the clkb activity toggle into clka.
- `WIN_W`, 8: monitor window is 2^WIN_W clka cycles.
- `MIN_EDGES`, 4: minimum toggle changes per window for clkb to count as alive.
- `SETTLE_CYC`, 16: clka cycles busy is held after each `sel_clkb` change.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clka` in 1: controller clock. All ports except `clkb` are in this domain.
- `clkb` in 1: monitored clock. Drives only the activity toggle flop.
- `req_clkb` in 1: level request; 1 = run on clkb.
- `sel_clkb` out 1: registered select to the mux `sel_clkb` input.
- `busy` out 1: switch in progress.
- `on_clkb` out 1: switch to clkb complete.
- `clkb_ok` out 1: clkb judged alive by the last completed window.
- `fail` out 1: sticky flag; clkb was lost or died while selected or switching.

## Operation
- Reset: all outputs 0, FSM in `ON_A`, monitor counters 0. The toggle flop in the clkb domain is also reset by `rst_n`.
- Monitor:
  - `tgl_b` inverts on every clkb rising edge.
  - It is synchronized through `SYNC_STAGES` clka flops, then edge-detected.
  - Each detected change increments `edge_cnt`, which saturates at `MIN_EDGES`.
  - The window counter runs freely over 2^WIN_W cycles.
  - In the last window cycle, `clkb_ok` <= (`edge_cnt` >= `MIN_EDGES`) and `edge_cnt` clears.
  - Counting is valid only for f_clkb <= f_clka/2. Faster clkb aliases, and that is a usage error.
- FSM states: `ON_A`, `SW_B`, `ON_B`, `SW_A`.
  - `ON_A`: `sel_clkb`=0. If `req_clkb` && `clkb_ok` && !`fail`: go to `SW_B`, `sel_clkb`<=1, load `cnt`=`SETTLE_CYC`-1. If `req_clkb`=0: clear `fail`.
  - `SW_B`: `busy`=1 and `cnt` decrements.
    - At `cnt`==0, go to `ON_B`.
    - If `clkb_ok` falls, go to `SW_A`: `sel_clkb`<=0, `fail`<=1, reload `cnt`. This takes priority over settle completion.
    - Dropping `req_clkb` does not abort the switch.
  - `ON_B`: `on_clkb`=1.
    - If !`clkb_ok`: go to `SW_A` with `fail`<=1.
    - Else if !`req_clkb`: go to `SW_A`.
    - In either case, `sel_clkb`<=0 and reload `cnt`.
  - `SW_A`: `busy`=1. Settles the full `SETTLE_CYC` regardless of `req_clkb`, then goes to `ON_A`.
- `busy`, `on_clkb` and `fail` are registered and decoded from the next state, so they align with `sel_clkb`.
- Recovering the mux itself after clkb dies mid-handover is outside this block's scope. This block only guarantees that `sel_clkb` drops and that `fail` is raised.

## Timing
- State transition, `sel_clkb` change and `busy` assertion all occur on the same clka edge after the condition is sampled.
- Settle: `busy` high for exactly `SETTLE_CYC` cycles, after which `on_clkb` rises (or `ON_A` is re-entered).
- `clkb_ok` latency:
  - Rise: at most 2·2^WIN_W + `SYNC_STAGES` + 1 cycles after clkb starts.
  - Fall: at most 2·2^WIN_W cycles after clkb stops.
- Fastest full round trip `ON_A` -> `ON_B` -> `ON_A`: 2·`SETTLE_CYC` + 2 cycles.
- Reset mid-operation: outputs go to 0 asynchronously, with no settle period.

## Structure
- Package `clk_sw_pkg`: state enum `clk_sw_state_t` (`ON_A`, `SW_B`, `ON_B`, `SW_A`) and default parameter constants.
- Sub-module `clk_sw_mon`: clkb toggle flop, synchronizer, window and edge counters; outputs `clkb_ok`. It is the only logic touching clkb.
- Top level: FSM plus settle counter; `cnt` width is $clog2(`SETTLE_CYC`).

## Test plan
- **Reset, clkb idle:** hold `rst_n`=0, then release with clkb static → all outputs 0 for 1000 cycles. `req_clkb`=1 → `sel_clkb` stays 0 and `fail` stays 0.
- **Normal switch:** clka 10 ns, clkb 40 ns → `clkb_ok`=1 within 520 cycles. Then `req_clkb`=1 → `sel_clkb`=1 and `busy`=1 on the next edge; `busy` lasts 16 cycles; then `on_clkb`=1.
- **Loss in `ON_B`:** stop clkb while in `ON_B` → within 512 cycles `clkb_ok`=0, then `sel_clkb`=0, `fail`=1, `busy` for 16 cycles, then `ON_A`. `req_clkb` held at 1 is ignored. `req_clkb`=0 for 1 cycle clears `fail`.
- **Request dropped during `SW_B`:** `req_clkb` 1→0 at settle cycle 5 → `on_clkb` pulses 1 cycle after 16 busy cycles, then `SW_A` follows with 16 more busy cycles.
- **Simultaneous loss and settle end:** `clkb_ok` falls in the cycle `cnt`==0 → `SW_A` is taken with `fail`=1; `on_clkb` never asserts.
- **Reset mid-switch:** `rst_n`=0 at settle cycle 8 → `sel_clkb`, `busy` and `fail` go to 0 immediately. After release, a fresh `clkb_ok` qualification is required before any switch.
